// File: rtl/fetch_pkg.sv
// Shared definitions for the buffered fetch stage: reset constants, the
// prefetch-queue entry layout and the credit-counter width helper.
package fetch_pkg;

    localparam int          FETCH_XLEN      = 32;
    localparam logic [31:0] FETCH_NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] FETCH_RESET_PC  = 32'h0000_0000;

    // Queue entry layout at the default address width.
    typedef struct packed {
        logic [31:0]           instr;
        logic [FETCH_XLEN-1:0] pc;
    } fetch_entry_t;

    // Counters and queue pointers need one extra bit so that a value of
    // DEPTH is representable and full can be told apart from empty.
    function automatic int credit_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO with clear. Pointers carry one extra MSB so that
// equal low bits with different MSBs means full.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           i_rst_n,
    input  logic                           i_push,
    input  logic [WIDTH-1:0]               i_push_data,
    input  logic                           i_pop,
    input  logic                           i_clear,
    output logic [WIDTH-1:0]               o_head,
    output logic                           o_full,
    output logic                           o_empty,
    output logic [credit_width(DEPTH)-1:0] o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = credit_width(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]    r_wptr;
    logic [CW-1:0]    r_rptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
    assign o_count   = r_wptr - r_rptr;
    assign o_head    = r_mem[r_rptr[AW-1:0]];
    assign w_do_push = i_push && !o_full && !i_clear;
    assign w_do_pop  = i_pop && !o_empty && !i_clear;

    // Storage write; contents are qualified by the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr[AW-1:0]] <= i_push_data;
        end
    end

    // Read/write pointer update with clear taking priority.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr <= {CW{1'b0}};
            r_rptr <= {CW{1'b0}};
        end else if (i_clear) begin
            r_wptr <= {CW{1'b0}};
            r_rptr <= {CW{1'b0}};
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + CW'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + CW'(1);
            end
        end
    end

endmodule

// File: rtl/fetch_stage_buffered.sv
// Buffered instruction fetch: owns the PC, issues credit-limited pipelined
// requests, tags responses with their issue address, queues them and feeds
// the IF/ID register. Responses outstanding at a redirect are discarded.
module fetch_stage_buffered
    import fetch_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter int              DEPTH     = 4,
    parameter logic [XLEN-1:0] RESET_PC  = XLEN'(FETCH_RESET_PC),
    parameter logic [31:0]     NOP_INSTR = FETCH_NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    input  logic            StallD,
    input  logic            FlushD,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic [31:0]     InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD
);

    localparam int CW = credit_width(DEPTH);

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
    } q_entry_t;

    localparam int EW = $bits(q_entry_t);

    logic [XLEN-1:0] r_pc;
    logic [CW-1:0]   r_inflight;
    logic [CW-1:0]   r_drop;
    logic            r_valid_d;
    logic [31:0]     r_instr_d;
    logic [XLEN-1:0] r_pc_d;
    logic [XLEN-1:0] r_pc_plus4_d;

    logic [CW:0]     w_credit_sum;
    logic            w_req_valid;
    logic            w_req_fire;
    logic            w_rsp_take;
    logic            w_rsp_push;
    logic            w_d_pop;
    q_entry_t        w_push_entry;
    q_entry_t        w_q_head;
    logic [EW-1:0]   w_q_head_bits;
    logic            w_q_full;
    logic            w_q_empty;
    logic [CW-1:0]   w_q_count;
    logic [XLEN-1:0] w_tag_head;
    logic            w_tag_full;
    logic            w_tag_empty;
    logic [CW-1:0]   w_tag_count;
    logic            w_unused_tag;

    // Requests are only issued while in-flight plus buffered words leave room
    // in the queue, which is what makes queue overflow impossible.
    assign w_credit_sum   = {1'b0, r_inflight} + {1'b0, w_q_count};
    assign w_req_valid    = rst && !PCSrcE && (w_credit_sum < (CW+1)'(DEPTH));
    assign w_req_fire     = w_req_valid && imem_req_ready;
    // A response with nothing outstanding is a protocol error and is ignored.
    assign w_rsp_take     = imem_rsp_valid && (r_inflight != {CW{1'b0}});
    assign w_rsp_push     = w_rsp_take && (r_drop == {CW{1'b0}}) && !PCSrcE;
    assign w_d_pop        = !PCSrcE && !FlushD && !StallD && !w_q_empty;

    assign w_push_entry.instr    = imem_rsp_data;
    assign w_push_entry.pc       = w_tag_head;
    assign w_push_entry.pc_plus4 = w_tag_head + XLEN'(4);
    assign w_q_head              = q_entry_t'(w_q_head_bits);

    // Tag FIFO status is implied by the in-flight counter.
    assign w_unused_tag = ^{w_tag_full, w_tag_empty, w_tag_count};

    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = r_pc;
    assign InstrD         = r_instr_d;
    assign PCD            = r_pc_d;
    assign PCPlus4D       = r_pc_plus4_d;
    assign ValidD         = r_valid_d;

    // Issue addresses of non-discarded in-flight requests, oldest first.
    fetch_queue #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag_fifo (
        .clk         (clk),
        .i_rst_n     (rst),
        .i_push      (w_req_fire),
        .i_push_data (r_pc),
        .i_pop       (w_rsp_push),
        .i_clear     (PCSrcE),
        .o_head      (w_tag_head),
        .o_full      (w_tag_full),
        .o_empty     (w_tag_empty),
        .o_count     (w_tag_count)
    );

    // Prefetch queue of returned instructions with their PC and PC+4.
    fetch_queue #(.WIDTH(EW), .DEPTH(DEPTH)) u_prefetch_q (
        .clk         (clk),
        .i_rst_n     (rst),
        .i_push      (w_rsp_push),
        .i_push_data (w_push_entry),
        .i_pop       (w_d_pop),
        .i_clear     (PCSrcE),
        .o_head      (w_q_head_bits),
        .o_full      (w_q_full),
        .o_empty     (w_q_empty),
        .o_count     (w_q_count)
    );

    // Program counter: redirect target, else advance on an accepted request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc <= RESET_PC;
        end else if (PCSrcE) begin
            r_pc <= PCTargetE;
        end else if (w_req_fire) begin
            r_pc <= r_pc + XLEN'(4);
        end
    end

    // In-flight and drop counters; a redirect turns everything still
    // outstanding (minus a response consumed this cycle) into drops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_inflight <= {CW{1'b0}};
            r_drop     <= {CW{1'b0}};
        end else begin
            r_inflight <= r_inflight + CW'(w_req_fire) - CW'(w_rsp_take);
            if (PCSrcE) begin
                r_drop <= r_inflight - CW'(w_rsp_take);
            end else if (w_rsp_take && (r_drop != {CW{1'b0}})) begin
                r_drop <= r_drop - CW'(1);
            end
        end
    end

    // IF/ID register: redirect and flush invalidate regardless of stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid_d    <= 1'b0;
            r_instr_d    <= NOP_INSTR;
            r_pc_d       <= {XLEN{1'b0}};
            r_pc_plus4_d <= {XLEN{1'b0}};
        end else if (PCSrcE || FlushD) begin
            r_valid_d <= 1'b0;
            r_instr_d <= NOP_INSTR;
        end else if (!StallD) begin
            if (!w_q_empty) begin
                r_valid_d    <= 1'b1;
                r_instr_d    <= w_q_head.instr;
                r_pc_d       <= w_q_head.pc;
                r_pc_plus4_d <= w_q_head.pc_plus4;
            end else begin
                r_valid_d <= 1'b0;
                r_instr_d <= NOP_INSTR;
            end
        end
    end

    // Queue overflow is excluded by the credit rule; full is kept for reuse.
    logic w_unused_full;
    assign w_unused_full = w_q_full;

endmodule
